fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Registered next-PC generator for the IF1 stage with an integrated return address stack (RAS).
//  Selects the next PC from four sources: EX resolution, ID late prediction, IF1 BTB/RAS prediction, and PC+4.
//  Issues the IF2/ID/EX pipeline flushes.
//  Parametrised in XLEN, reset vector and RAS depth; repairs the RAS pointer on every redirect.
// PARAMETERS
//  XLEN       32  datapath/PC width
//  RESET_PC   0   PC value loaded on reset
//  RAS_DEPTH  8   RAS entries, power of 2 and >=2; PW = $clog2(RAS_DEPTH)
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous reset, active-high
//  stall          in   1     hold PC and RAS (redirects still load)
//  if1_btb_hit    in   1     BTB hit for the current PC
//  if1_branch     in   1     current PC is a conditional branch
//  if1_jump       in   1     current PC is a jump
//  if1_call       in   1     jump writes the link register (RAS push)
//  if1_ret        in   1     jump is a return (RAS pop)
//  if1_pred       in   2     2-bit counter; taken when bit1 = 1
//  if1_target     in   XLEN  BTB target
//  id_redirect    in   1     ID late prediction (BTB miss, taken branch or JAL)
//  id_target      in   XLEN  ID target
//  id_ras_ptr     in   PW    RAS snapshot carried with the ID instruction
//  id_ras_cnt     in   PW+1  RAS snapshot carried with the ID instruction
//  ex_redirect    in   1     EX mispredict or JALR resolution
//  ex_kill_ex     in   1     also flush EX (taken mispredict, JALR)
//  ex_jalr        in   1     target needs lsb cleared
//  ex_target      in   XLEN  resolved next PC
//  ex_ras_ptr     in   PW    RAS snapshot carried with the EX instruction
//  ex_ras_cnt     in   PW+1  RAS snapshot carried with the EX instruction
//  pc             out  XLEN  current IF1 PC (registered)
//  pc_4           out  XLEN  pc+4, mod 2^XLEN
//  next_pc        out  XLEN  combinational next PC
//  ras_ptr        out  PW    current RAS state, to be piped with the instruction
//  ras_cnt        out  PW+1  current RAS state, to be piped with the instruction
//  if2_flush      out  1     comb flush of IF2
//  id_flush       out  1     comb flush of ID
//  ex_flush       out  1     comb flush of EX
//  perf_ex_redir  out  32    EX redirect event counter
//  perf_id_redir  out  32    ID redirect event counter
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, ras_ptr=0, ras_cnt=0, RAS entries=0, perf counters=0.
//    Flushes are combinational and deassert once inputs are quiet.
//  - next_pc priority, highest first:
//      1. ex_redirect: ex_target, with lsb forced to 0 when ex_jalr.
//         if2_flush=id_flush=1; ex_flush=ex_kill_ex.
//      2. id_redirect: id_target. if2_flush=id_flush=1.
//      3. if1_btb_hit & if1_ret & ras_cnt!=0: RAS[ras_ptr-1].
//      4. if1_btb_hit & (if1_jump | (if1_branch & if1_pred[1])): if1_target.
//      5. Otherwise pc_4.
//  - PC register: loads next_pc every cycle when !stall. Also loads when ex_redirect or id_redirect,
//    even if stall=1. Stall never holds a redirect, so latency is exactly 1 cycle.
//  - RAS speculative update: only when !stall, no redirect, and if1_btb_hit.
//      - Push (if1_call & !if1_ret): RAS[ras_ptr]=pc_4; ptr+=1 mod DEPTH; cnt=min(cnt+1,DEPTH).
//        When full, the push overwrites the oldest entry; cnt saturates.
//      - Pop (if1_ret & !if1_call): when cnt!=0, ptr-=1 and cnt-=1.
//        Pop on empty is a no-op; the prediction falls to rule 4.
//      - Push and pop together (call+ret): overwrite RAS[ptr-1] with pc_4; ptr and cnt unchanged.
//        On empty, this acts as a push.
//  - RAS repair:
//      - ex_redirect: ptr/cnt <= ex_ras_ptr/ex_ras_cnt.
//      - Else id_redirect: ptr/cnt <= id_ras_ptr/id_ras_cnt.
//      - Entry contents are never restored (pointer-only repair).
//      - EX repair wins over ID when both fire in the same cycle.
//  - Arithmetic: all PC math is mod 2^XLEN; pointer math is mod RAS_DEPTH.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    perf_ex_redir increments on each cycle with ex_redirect=1.
//    perf_id_redir increments on each cycle with id_redirect=1 & !ex_redirect.
//    Both are 32-bit, wrap at 2^32, and reset to 0.
//  FETCH_PERF_CNT_EN undefined: counters are not built; both outputs are tied to 0.
// TESTING
//  1. rst pulse mid-run with RESET_PC=32'h100 -> pc=0x100 immediately; next edge pc=0x104;
//     ras_cnt=0; all flushes 0.
//  2. Call at pc=0x200, then ret with btb_hit at pc=0x800 -> next_pc=0x204 (ignores if1_target);
//     ras_cnt goes 1 -> 0.
//  3. RAS_DEPTH=4, push 5 calls, then pop 5 times -> returns to the 5th..2nd call sites;
//     5th pop falls back to if1_target.
//  4. id_redirect=1 and ex_redirect=1 (ex_jalr, ex_target=0x3003) with stall=1 ->
//     next pc=0x3002; ex_flush=ex_kill_ex; RAS ptr/cnt = ex snapshot.
//  5. Call and ret in the same cycle at cnt=2 -> cnt stays 2; top entry=pc_4.
//  6. With FETCH_PERF_CNT_EN: 3 EX redirects and 2 ID-only redirects -> perf_ex_redir=3, perf_id_redir=2.
//     Without the macro: both read 0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: registered IF1 next-PC generator with an integrated return
// address stack. Optional redirect event counters are built when the macro
// FETCH_PERF_CNT_EN is defined; otherwise both counter outputs read 0.
module fetch_pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              RAS_DEPTH = 8,
   localparam int             PW        = $clog2(RAS_DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            if1_btb_hit,
   input  logic            if1_branch,
   input  logic            if1_jump,
   input  logic            if1_call,
   input  logic            if1_ret,
   input  logic [1:0]      if1_pred,
   input  logic [XLEN-1:0] if1_target,
   input  logic            id_redirect,
   input  logic [XLEN-1:0] id_target,
   input  logic [PW-1:0]   id_ras_ptr,
   input  logic [PW:0]     id_ras_cnt,
   input  logic            ex_redirect,
   input  logic            ex_kill_ex,
   input  logic            ex_jalr,
   input  logic [XLEN-1:0] ex_target,
   input  logic [PW-1:0]   ex_ras_ptr,
   input  logic [PW:0]     ex_ras_cnt,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_4,
   output logic [XLEN-1:0] next_pc,
   output logic [PW-1:0]   ras_ptr,
   output logic [PW:0]     ras_cnt,
   output logic            if2_flush,
   output logic            id_flush,
   output logic            ex_flush,
   output logic [31:0]     perf_ex_redir,
   output logic [31:0]     perf_id_redir
);

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   top_idx;
   logic [XLEN-1:0] ras_top;
   logic            ras_nonempty;
   logic            ras_full;
   logic            redirect;
   logic            ras_upd;
   logic            do_push;
   logic            do_repl;
   logic            do_pop;
   logic            unused_pred;

   // Only the taken/not-taken bit of the 2-bit counter matters here.
   assign unused_pred = if1_pred[0];

   assign pc_4         = pc + XLEN'(4);
   assign top_idx      = ras_ptr - PW'(1);
   assign ras_top      = ras_mem[top_idx];
   assign ras_nonempty = (ras_cnt != '0);
   assign ras_full     = (ras_cnt == (PW+1)'(RAS_DEPTH));
   assign redirect     = ex_redirect | id_redirect;

   // Speculative RAS update happens only on an undisturbed, unstalled BTB hit.
   // A call+ret on an empty stack degenerates into a plain push.
   assign ras_upd = ~stall & ~redirect & if1_btb_hit;
   assign do_push = ras_upd & if1_call & (~if1_ret | ~ras_nonempty);
   assign do_repl = ras_upd & if1_call & if1_ret & ras_nonempty;
   assign do_pop  = ras_upd & if1_ret & ~if1_call & ras_nonempty;

   // Next-PC priority mux and flush generation.
   always_comb begin
      next_pc   = pc_4;
      if2_flush = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      if (ex_redirect) begin
         next_pc   = {ex_target[XLEN-1:1], ex_target[0] & ~ex_jalr};
         if2_flush = 1'b1;
         id_flush  = 1'b1;
         ex_flush  = ex_kill_ex;
      end else if (id_redirect) begin
         next_pc   = id_target;
         if2_flush = 1'b1;
         id_flush  = 1'b1;
      end else if (if1_btb_hit & if1_ret & ras_nonempty) begin
         next_pc = ras_top;
      end else if (if1_btb_hit & (if1_jump | (if1_branch & if1_pred[1]))) begin
         next_pc = if1_target;
      end
   end

   // PC register: a redirect always loads, even under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= RESET_PC;
      else if (~stall | redirect)
         pc <= next_pc;
   end

   // RAS pointer/count: redirect repairs from the carried snapshot (EX wins).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (ex_redirect) begin
         ras_ptr <= ex_ras_ptr;
         ras_cnt <= ex_ras_cnt;
      end else if (id_redirect) begin
         ras_ptr <= id_ras_ptr;
         ras_cnt <= id_ras_cnt;
      end else if (do_push) begin
         ras_ptr <= ras_ptr + PW'(1);
         if (!ras_full)
            ras_cnt <= ras_cnt + (PW+1)'(1);
      end else if (do_pop) begin
         ras_ptr <= ras_ptr - PW'(1);
         ras_cnt <= ras_cnt - (PW+1)'(1);
      end
   end

   // RAS entries: a push writes at ptr (overwriting the oldest when full),
   // a call+ret replaces the current top. Contents are never repaired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RAS_DEPTH; i++)
            ras_mem[i] <= '0;
      end else if (do_push) begin
         ras_mem[ras_ptr] <= pc_4;
      end else if (do_repl) begin
         ras_mem[top_idx] <= pc_4;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // EX redirect event counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         perf_ex_redir <= '0;
      else if (ex_redirect)
         perf_ex_redir <= perf_ex_redir + 32'd1;
   end

   // ID redirect counter; only counts when EX is not also redirecting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         perf_id_redir <= '0;
      else if (id_redirect & ~ex_redirect)
         perf_id_redir <= perf_id_redir + 32'd1;
   end
`else
   assign perf_ex_redir = 32'd0;
   assign perf_id_redir = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit (RESET_PC=0x100, RAS_DEPTH=4).
// Stimulus pushes expectations; the monitor drains them on the falling edge.
module tb_fetch_pc_unit;
   localparam int XLEN = 32;
   localparam int DEPTH = 4;
   localparam int PW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall, if1_btb_hit, if1_branch, if1_jump, if1_call, if1_ret;
   logic [1:0]      if1_pred;
   logic [XLEN-1:0] if1_target, id_target, ex_target;
   logic            id_redirect, ex_redirect, ex_kill_ex, ex_jalr;
   logic [PW-1:0]   id_ras_ptr, ex_ras_ptr;
   logic [PW:0]     id_ras_cnt, ex_ras_cnt;
   logic [XLEN-1:0] pc, pc_4, next_pc;
   logic [PW-1:0]   ras_ptr;
   logic [PW:0]     ras_cnt;
   logic            if2_flush, id_flush, ex_flush;
   logic [31:0]     perf_ex_redir, perf_id_redir;

   fetch_pc_unit #(.XLEN(XLEN), .RESET_PC(32'h100), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .if1_btb_hit(if1_btb_hit),
      .if1_branch(if1_branch), .if1_jump(if1_jump), .if1_call(if1_call),
      .if1_ret(if1_ret), .if1_pred(if1_pred), .if1_target(if1_target),
      .id_redirect(id_redirect), .id_target(id_target), .id_ras_ptr(id_ras_ptr),
      .id_ras_cnt(id_ras_cnt), .ex_redirect(ex_redirect), .ex_kill_ex(ex_kill_ex),
      .ex_jalr(ex_jalr), .ex_target(ex_target), .ex_ras_ptr(ex_ras_ptr),
      .ex_ras_cnt(ex_ras_cnt), .pc(pc), .pc_4(pc_4), .next_pc(next_pc),
      .ras_ptr(ras_ptr), .ras_cnt(ras_cnt), .if2_flush(if2_flush),
      .id_flush(id_flush), .ex_flush(ex_flush), .perf_ex_redir(perf_ex_redir),
      .perf_id_redir(perf_id_redir)
   );

   always #5 clk = ~clk;

   typedef enum int {S_PC, S_NPC, S_PC4, S_PTR, S_CNT, S_FL, S_PEX, S_PID} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   task automatic expect_v(input string name, input sel_t sel, input logic [31:0] val);
      exp_t e;
      e.name = name; e.sel = sel; e.val = val;
      q.push_back(e);
   endtask

   // Monitor: compare every queued expectation against the settled outputs.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.sel)
            S_PC:    act = pc;
            S_NPC:   act = next_pc;
            S_PC4:   act = pc_4;
            S_PTR:   act = 32'(ras_ptr);
            S_CNT:   act = 32'(ras_cnt);
            S_FL:    act = {29'd0, if2_flush, id_flush, ex_flush};
            S_PEX:   act = perf_ex_redir;
            default: act = perf_id_redir;
         endcase
         total++;
         if (act !== e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.name, act, e.val);
         end
      end
   end

   task automatic quiet();
      stall = 0; if1_btb_hit = 0; if1_branch = 0; if1_jump = 0; if1_call = 0;
      if1_ret = 0; if1_pred = 0; if1_target = 0; id_redirect = 0; id_target = 0;
      id_ras_ptr = 0; id_ras_cnt = 0; ex_redirect = 0; ex_kill_ex = 0; ex_jalr = 0;
      ex_target = 0; ex_ras_ptr = 0; ex_ras_cnt = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_pc(input logic [31:0] t);
      quiet();
      id_redirect = 1; id_target = t;
      step();
      quiet();
   endtask

   task automatic jmp(input logic call, input logic ret, input logic [31:0] tgt);
      quiet();
      if1_btb_hit = 1; if1_jump = 1; if1_call = call; if1_ret = ret; if1_target = tgt;
   endtask

   initial begin
      quiet();
      rst = 1;
      step(); step();
      expect_v("rst_pc", S_PC, 32'h100);
      expect_v("rst_cnt", S_CNT, 0);
      expect_v("rst_ptr", S_PTR, 0);
      expect_v("rst_flush", S_FL, 0);
      expect_v("rst_pex", S_PEX, 0);
      expect_v("rst_pid", S_PID, 0);
      @(negedge clk); #1 rst = 0;
      step();
      expect_v("first_pc4", S_PC, 32'h104);

      // pc_4 wraps mod 2^32; ID redirect flushes IF2/ID only
      quiet(); id_redirect = 1; id_target = 32'hFFFF_FFFC;
      expect_v("id_flush", S_FL, 3'b110);
      expect_v("id_npc", S_NPC, 32'hFFFF_FFFC);
      step(); quiet();
      expect_v("wrap_pc4", S_PC4, 0);

      // call at 0x200, return at 0x800
      goto_pc(32'h200);
      jmp(1, 0, 32'h800);
      expect_v("call_npc", S_NPC, 32'h800);
      step();
      expect_v("call_cnt", S_CNT, 1);
      jmp(0, 1, 32'h900);
      expect_v("ret_npc", S_NPC, 32'h204);
      step(); quiet();
      expect_v("ret_pc", S_PC, 32'h204);
      expect_v("ret_cnt", S_CNT, 0);

      // not-taken vs taken conditional branch on BTB hit
      quiet(); if1_btb_hit = 1; if1_branch = 1; if1_pred = 2'b01; if1_target = 32'h40;
      expect_v("br_nt", S_NPC, 32'h208);
      step();
      if1_pred = 2'b10;
      expect_v("br_t", S_NPC, 32'h40);
      step();

      // overflow a 4-deep RAS with 5 calls, then pop 5 times
      goto_pc(32'h1000);
      for (int k = 1; k <= 5; k++) begin
         jmp(1, 0, 32'((k + 1) << 12));
         step();
      end
      quiet();
      expect_v("ovf_cnt", S_CNT, 4);
      expect_v("ovf_ptr", S_PTR, 1);
      jmp(0, 1, 32'hA000); expect_v("pop1", S_NPC, 32'h5004); step();
      jmp(0, 1, 32'hA000); expect_v("pop2", S_NPC, 32'h4004); step();
      jmp(0, 1, 32'hA000); expect_v("pop3", S_NPC, 32'h3004); step();
      jmp(0, 1, 32'hA000); expect_v("pop4", S_NPC, 32'h2004); step();
      expect_v("pop4_cnt", S_CNT, 0);
      jmp(0, 1, 32'hA000); expect_v("pop5_btb", S_NPC, 32'hA000); step();
      quiet();
      expect_v("pop5_cnt", S_CNT, 0);
      expect_v("pop5_ptr", S_PTR, 1);

      // call+ret in one cycle at cnt=2 replaces the top entry
      goto_pc(32'h7000);
      jmp(1, 0, 32'h7100); step();
      jmp(1, 0, 32'h7200); step();
      jmp(1, 1, 32'h7300);
      expect_v("cr_npc", S_NPC, 32'h7104);
      step();
      expect_v("cr_cnt", S_CNT, 2);
      expect_v("cr_ptr", S_PTR, 2);
      jmp(0, 1, 32'h7300);
      expect_v("cr_top", S_NPC, 32'h7204);
      step();

      // stall holds PC and RAS
      jmp(1, 0, 32'h9000); stall = 1;
      expect_v("stall_cnt0", S_CNT, 1);
      step(); step();
      expect_v("stall_pc", S_PC, 32'h7204);
      expect_v("stall_cnt", S_CNT, 1);

      // EX and ID redirect together under stall: EX wins, jalr clears lsb
      quiet(); stall = 1;
      id_redirect = 1; id_target = 32'h5555; id_ras_ptr = 3; id_ras_cnt = 1;
      ex_redirect = 1; ex_jalr = 1; ex_kill_ex = 1; ex_target = 32'h3003;
      ex_ras_ptr = 2; ex_ras_cnt = 3;
      expect_v("ex_npc", S_NPC, 32'h3002);
      expect_v("ex_flush_k", S_FL, 3'b111);
      step();
      ex_kill_ex = 0; ex_jalr = 0; id_redirect = 0; ex_target = 32'h4001;
      expect_v("ex_pc", S_PC, 32'h3002);
      expect_v("ex_ptr", S_PTR, 2);
      expect_v("ex_cnt", S_CNT, 3);
      expect_v("ex_flush_nk", S_FL, 3'b110);
      expect_v("ex_nojalr", S_NPC, 32'h4001);
      step(); quiet();

      // asynchronous reset pulse mid-run
      @(posedge clk); #1 rst = 1;
      expect_v("arst_pc", S_PC, 32'h100);
      expect_v("arst_cnt", S_CNT, 0);
      expect_v("arst_flush", S_FL, 0);
      expect_v("arst_pex", S_PEX, 0);
      @(negedge clk); #1 rst = 0;
      step();
      expect_v("arst_next", S_PC, 32'h104);

      // perf counters: 3 EX (one with ID too), 2 ID-only
      quiet(); ex_redirect = 1; ex_target = 32'h10; step();
      ex_target = 32'h20; step();
      id_redirect = 1; id_target = 32'h30; step();
      ex_redirect = 0; step();
      step();
      quiet();
`ifdef FETCH_PERF_CNT_EN
      expect_v("perf_ex", S_PEX, 3);
      expect_v("perf_id", S_PID, 2);
`else
      expect_v("perf_ex", S_PEX, 0);
      expect_v("perf_id", S_PID, 0);
`endif
      expect_v("perf_pc", S_PC, 32'h30);
      @(negedge clk); #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
